// File: rtl/gsm_tx_arbiter_pkg.sv
// gsm_arb_pkg: shared types and helpers for the GSM uart_tx channel arbiter.
//   arb_state_t  : arbiter FSM states (IDLE, LOCKED)
//   BYTE_W       : width of one channel byte
//   next_rr_idx  : advance a round-robin pointer by one, wrapping modulo n
//                  and stepping over the strict-priority index
package gsm_arb_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  function automatic int next_rr_idx(input int ptr, input int skip, input int n);
    int nxt;
    nxt = (ptr + 1) % n;
    // The priority requester never takes part in the rotation.
    if ((nxt == skip) && (n > 1)) nxt = (nxt + 1) % n;
    return nxt;
  endfunction

endpackage

// File: rtl/gsm_tx_arbiter_if.sv
// gsm_tx_arbiter_if: requester-side and uart_tx-side signals of the arbiter.
//   req_data  : 8 bits per requester, requester i on [8i+7:8i]
//   req_valid : requester i has a byte available
//   req_last  : presented byte closes its packet
//   req_ready : requester i's byte is accepted this cycle
//   tx_data / tx_valid / tx_ready : byte channel into uart_tx
//   grant     : one-hot current owner, zero when idle
//   busy      : a packet is locked
//   abort     : one-cycle pulse on forced release
// Modports: slave = arbiter side, master = sources/uart_tx side.
interface gsm_tx_arbiter_if #(
  parameter int NUM_REQ = 3
);
  import gsm_arb_pkg::*;

  logic [BYTE_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic [BYTE_W-1:0]         tx_data;
  logic                      tx_valid;
  logic                      tx_ready;
  logic [NUM_REQ-1:0]        grant;
  logic                      busy;
  logic                      abort;

  modport slave (
    input  req_data, req_valid, req_last, tx_ready,
    output req_ready, tx_data, tx_valid, grant, busy, abort
  );

  modport master (
    output req_data, req_valid, req_last, tx_ready,
    input  req_ready, tx_data, tx_valid, grant, busy, abort
  );

endinterface

// File: rtl/gsm_tx_arbiter_rr_picker.sv
// gsm_rr_picker: combinational winner selection for the arbiter.
//   req_valid : per-requester request lines
//   rr_ptr    : first index searched for round-robin service
//   winner    : one-hot winner, zero when nothing is requesting
// PRIO_REQ wins outright when valid; otherwise the first valid index at or
// above rr_ptr (wrapping, PRIO_REQ excluded) wins.
module gsm_rr_picker #(
  parameter int NUM_REQ  = 3,
  parameter int PRIO_REQ = 0,
  parameter int PTR_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] winner
);

  // Distance of index i above the pointer, modulo n.
  function automatic int rr_dist(input int i, input int p, input int n);
    return (i >= p) ? (i - p) : (i + n - p);
  endfunction

  logic found;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    if (req_valid[PRIO_REQ]) begin
      winner[PRIO_REQ] = 1'b1;
    end else begin
      // Scan by increasing distance so only loop indices touch the vectors.
      for (int off = 0; off < NUM_REQ; off++) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (!found && (i != PRIO_REQ) && req_valid[i] &&
              (rr_dist(i, int'(rr_ptr), NUM_REQ) == off)) begin
            winner[i] = 1'b1;
            found     = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/gsm_tx_arbiter.sv
// gsm_tx_arbiter: packet-locked arbiter sharing the GSM uart_tx byte channel
// among NUM_REQ sources. PRIO_REQ (emergency alerts) wins every arbitration,
// the rest are served round-robin. A grant holds until the owner's byte
// flagged last is transferred.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : gsm_tx_arbiter_if.slave (request lanes, uart_tx channel,
//              grant/busy/abort status)
// Optional: define ARB_TIMEOUT_EN to force-release a packet that sees no
// transfer for TIMEOUT_CYCLES locked cycles (abort pulses, rr advances).
module gsm_tx_arbiter
  import gsm_arb_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int PRIO_REQ       = 0,
  parameter int TIMEOUT_CYCLES = 2_500_000
) (
  input  logic              clk,
  input  logic              rst,
  gsm_tx_arbiter_if.slave   bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] RR_RESET = PTR_W'((PRIO_REQ + 1) % NUM_REQ);

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q;
  logic [NUM_REQ-1:0] winner;
  logic [PTR_W-1:0]   rr_ptr_q;
  logic [PTR_W-1:0]   owner_idx;
  logic               owner_valid;
  logic               owner_last;
  logic [BYTE_W-1:0]  owner_data;
  logic               xfer;
  logic               timeout;
  logic               release_pkt;

  gsm_rr_picker #(
    .NUM_REQ  (NUM_REQ),
    .PRIO_REQ (PRIO_REQ),
    .PTR_W    (PTR_W)
  ) u_picker (
    .req_valid (bus.req_valid),
    .rr_ptr    (rr_ptr_q),
    .winner    (winner)
  );

  // Owner lane select; grant_q is zero in IDLE so everything reads as idle.
  always_comb begin
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    owner_data  = '0;
    owner_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        owner_valid = bus.req_valid[i];
        owner_last  = bus.req_last[i];
        owner_data  = bus.req_data[BYTE_W*i +: BYTE_W];
        owner_idx   = PTR_W'(i);
      end
    end
  end

  assign xfer        = (state_q == LOCKED) && owner_valid && bus.tx_ready;
  assign release_pkt = (xfer && owner_last) || timeout;

`ifdef ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q;

  // Counts locked cycles without a transfer; idle time counts as a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q <= '0;
    end else if ((state_q == IDLE) || xfer || timeout) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + TO_W'(1);
    end
  end

  assign timeout = (state_q == LOCKED) && !xfer &&
                   (to_cnt_q == TO_W'(TIMEOUT_CYCLES));
`else
  assign timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|winner)    state_d = LOCKED;
      LOCKED:  if (release_pkt) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q  <= '0;
      rr_ptr_q <= RR_RESET;
    end else if (state_q == IDLE) begin
      grant_q <= winner;
    end else if (release_pkt) begin
      grant_q <= '0;
      if (!grant_q[PRIO_REQ]) begin
        rr_ptr_q <= PTR_W'(next_rr_idx(int'(owner_idx), PRIO_REQ, NUM_REQ));
      end
    end
  end

  // Outputs
  always_comb begin
    bus.tx_valid  = (state_q == LOCKED) && owner_valid;
    bus.tx_data   = bus.tx_valid ? owner_data : '0;
    bus.req_ready = ((state_q == LOCKED) && bus.tx_ready) ? grant_q : '0;
    bus.grant     = grant_q;
    bus.busy      = (state_q == LOCKED);
    bus.abort     = timeout;
  end

endmodule

// File: tb/tb_gsm_tx_arbiter.sv
// tb_gsm_tx_arbiter: directed, table-driven bench for gsm_tx_arbiter with
// three requesters, PRIO_REQ=0 and TIMEOUT_CYCLES=10. Inputs change on the
// falling edge; outputs are compared 1 ns later.
module tb_gsm_tx_arbiter;

  localparam int N  = 3;
  localparam int TO = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  gsm_tx_arbiter_if #(.NUM_REQ(N)) bus ();

  gsm_tx_arbiter #(
    .NUM_REQ        (N),
    .PRIO_REQ       (0),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [2:0]  v;
    logic [2:0]  l;
    logic [23:0] d;
    logic        rdy;
    logic [2:0]  g;
    logic        b;
    logic        tv;
    logic [7:0]  td;
    logic [2:0]  rr;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic [2:0] v, input logic [2:0] l, input logic [23:0] d,
                     input logic rdy, input logic [2:0] g, input logic b,
                     input logic tv, input logic [7:0] td, input logic [2:0] rr);
    vec_t e;
    e.v = v; e.l = l; e.d = d; e.rdy = rdy;
    e.g = g; e.b = b; e.tv = tv; e.td = td; e.rr = rr;
    vt.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] v, input logic [2:0] l,
                       input logic [23:0] d, input logic rdy);
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_data  = d;
    bus.tx_ready  = rdy;
  endtask

  task automatic idle_vec(input logic [2:0] v, input logic [2:0] l, input logic [23:0] d);
    add(v, l, d, 1'b1, 3'b000, 1'b0, 1'b0, 8'h00, 3'b000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n_abort;
    bit seen;

    drive(3'b000, 3'b000, 24'h0, 1'b1);

    // single source: req1 sends 41 54 0D
    idle_vec(3'b010, 3'b000, 24'h004100);
    add(3'b010, 3'b000, 24'h004100, 1, 3'b010, 1, 1, 8'h41, 3'b010);
    add(3'b010, 3'b000, 24'h005400, 1, 3'b010, 1, 1, 8'h54, 3'b010);
    add(3'b010, 3'b010, 24'h000D00, 1, 3'b010, 1, 1, 8'h0D, 3'b010);
    idle_vec(3'b000, 3'b000, 24'h0);
    // priority: req0 beats req2
    idle_vec(3'b101, 3'b000, 24'hC000A0);
    add(3'b101, 3'b000, 24'hC000A0, 1, 3'b001, 1, 1, 8'hA0, 3'b001);
    add(3'b101, 3'b001, 24'hC000A1, 1, 3'b001, 1, 1, 8'hA1, 3'b001);
    idle_vec(3'b100, 3'b100, 24'hC00000);
    add(3'b100, 3'b100, 24'hC00000, 1, 3'b100, 1, 1, 8'hC0, 3'b100);
    idle_vec(3'b000, 3'b000, 24'h0);
    // round-robin: 1-byte packets from req1 and req2
    for (int k = 0; k < 2; k++) begin
      idle_vec(3'b110, 3'b110, 24'h221100);
      add(3'b110, 3'b110, 24'h221100, 1, 3'b010, 1, 1, 8'h11, 3'b010);
      idle_vec(3'b110, 3'b110, 24'h221100);
      add(3'b110, 3'b110, 24'h221100, 1, 3'b100, 1, 1, 8'h22, 3'b100);
    end
    // back-pressure: tx_ready low for 5 cycles mid-packet
    idle_vec(3'b100, 3'b000, 24'h310000);
    add(3'b100, 3'b000, 24'h310000, 1, 3'b100, 1, 1, 8'h31, 3'b100);
    for (int k = 0; k < 5; k++)
      add(3'b100, 3'b000, 24'h320000, 0, 3'b100, 1, 1, 8'h32, 3'b000);
    add(3'b100, 3'b000, 24'h320000, 1, 3'b100, 1, 1, 8'h32, 3'b100);
    add(3'b100, 3'b100, 24'h330000, 1, 3'b100, 1, 1, 8'h33, 3'b100);
    idle_vec(3'b000, 3'b000, 24'h0);
    // no pre-emption: req0 arrives during req2's 4-byte packet
    idle_vec(3'b100, 3'b000, 24'h510000);
    add(3'b100, 3'b000, 24'h510000, 1, 3'b100, 1, 1, 8'h51, 3'b100);
    add(3'b101, 3'b000, 24'h5200E0, 1, 3'b100, 1, 1, 8'h52, 3'b100);
    add(3'b101, 3'b000, 24'h5300E0, 1, 3'b100, 1, 1, 8'h53, 3'b100);
    add(3'b101, 3'b100, 24'h5400E0, 1, 3'b100, 1, 1, 8'h54, 3'b100);
    idle_vec(3'b001, 3'b001, 24'h0000E0);
    add(3'b001, 3'b001, 24'h0000E0, 1, 3'b001, 1, 1, 8'hE0, 3'b001);
    // owner stalls with req_valid low: grant held, data reads 0
    idle_vec(3'b010, 3'b010, 24'h006100);
    add(3'b000, 3'b000, 24'h000000, 1, 3'b010, 1, 0, 8'h00, 3'b010);
    add(3'b000, 3'b000, 24'h000000, 1, 3'b010, 1, 0, 8'h00, 3'b010);
    add(3'b010, 3'b010, 24'h006100, 1, 3'b010, 1, 1, 8'h61, 3'b010);
    idle_vec(3'b000, 3'b000, 24'h0);

    // reset state
    #2 rst = 1'b1;
    @(negedge clk); #1;
    chk("rst grant", 32'(bus.grant), 0);
    chk("rst busy", 32'(bus.busy), 0);
    chk("rst abort", 32'(bus.abort), 0);
    chk("rst req_ready", 32'(bus.req_ready), 0);
    chk("rst tx_valid", 32'(bus.tx_valid), 0);
    chk("rst tx_data", 32'(bus.tx_data), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      drive(vt[i].v, vt[i].l, vt[i].d, vt[i].rdy);
      #1;
      chk($sformatf("v%0d grant", i), 32'(bus.grant), 32'(vt[i].g));
      chk($sformatf("v%0d busy", i), 32'(bus.busy), 32'(vt[i].b));
      chk($sformatf("v%0d tx_valid", i), 32'(bus.tx_valid), 32'(vt[i].tv));
      chk($sformatf("v%0d tx_data", i), 32'(bus.tx_data), 32'(vt[i].td));
      chk($sformatf("v%0d req_ready", i), 32'(bus.req_ready), 32'(vt[i].rr));
      chk($sformatf("v%0d abort", i), 32'(bus.abort), 0);
    end

`ifdef ARB_TIMEOUT_EN
    // req1 sends one byte then stalls; req2 waits behind it
    @(negedge clk); drive(3'b010, 3'b000, 24'h007100, 1'b1); #1;
    chk("to idle grant", 32'(bus.grant), 0);
    @(negedge clk); #1;
    chk("to grant1", 32'(bus.grant), 32'b010);
    chk("to byte1", 32'(bus.tx_data), 32'h71);
    @(negedge clk); drive(3'b100, 3'b100, 24'h810000, 1'b1); #1;
    seen = 1'b0;
    n_abort = -1;
    for (int j = 0; j < 50 && !seen; j++) begin
      if (j > 0) begin @(negedge clk); #1; end
      if (bus.abort === 1'b1) begin seen = 1'b1; n_abort = j; end
    end
    chk("to abort seen", 32'(seen), 1);
    chk("to stall cycles", 32'(n_abort), TO);
    chk("to grant at abort", 32'(bus.grant), 32'b010);
    @(negedge clk); #1;
    chk("to abort pulse width", 32'(bus.abort), 0);
    chk("to grant cleared", 32'(bus.grant), 0);
    chk("to busy cleared", 32'(bus.busy), 0);
    @(negedge clk); #1;
    chk("to req2 grant", 32'(bus.grant), 32'b100);
    chk("to req2 data", 32'(bus.tx_data), 32'h81);
    @(negedge clk); drive(3'b000, 3'b000, 24'h0, 1'b1); #1;
    chk("to end busy", 32'(bus.busy), 0);
`endif

    // reset in the middle of a packet clears the grant at once
    @(negedge clk); drive(3'b010, 3'b000, 24'h007700, 1'b1); #1;
    chk("mr idle", 32'(bus.grant), 0);
    @(negedge clk); #1;
    chk("mr grant", 32'(bus.grant), 32'b010);
    chk("mr data", 32'(bus.tx_data), 32'h77);
    #2 rst = 1'b1;
    #1;
    chk("mr async grant", 32'(bus.grant), 0);
    chk("mr async busy", 32'(bus.busy), 0);
    chk("mr async tx_valid", 32'(bus.tx_valid), 0);
    chk("mr async req_ready", 32'(bus.req_ready), 0);
    @(negedge clk); rst = 1'b0; #1;
    chk("mr post idle", 32'(bus.grant), 0);
    @(negedge clk); drive(3'b010, 3'b010, 24'h007800, 1'b1); #1;
    chk("mr regrant", 32'(bus.grant), 32'b010);
    chk("mr restart data", 32'(bus.tx_data), 32'h78);
    @(negedge clk); drive(3'b000, 3'b000, 24'h0, 1'b1); #1;
    chk("mr done busy", 32'(bus.busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gsm_tx_arbiter.md
Name: gsm_tx_arbiter

Overview:
- Shares the single GSM-side uart_tx byte channel between NUM_REQ packet sources, e.g. alert message generator, AT-command init sequencer, periodic status reporter.
- Grants are packet-locked: a requester keeps the channel from its first byte until its byte flagged last.
- Requester PRIO_REQ (the emergency alert path) wins every arbitration; all other requesters are served round-robin.
- Sits between the message sources and uart_tx; its output drives the uart_tx tx_data/tx_valid/tx_ready interface.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- PRIO_REQ, 0, index of the strict-priority requester.
- TIMEOUT_CYCLES, 2_500_000, idle cycles inside a locked packet before forced release (only with ARB_TIMEOUT_EN); 100 ms at 25 MHz.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req_data  in  8*NUM_REQ  byte from each requester; requester i uses bits [8i+7:8i]
- req_valid  in  NUM_REQ  requester i has a byte available
- req_last  in  NUM_REQ  the byte presented is the last of its packet
- req_ready  out  NUM_REQ  byte from requester i is accepted this cycle
- tx_data  out  8  byte to uart_tx
- tx_valid  out  1  byte valid to uart_tx
- tx_ready  in  1  uart_tx can accept a byte
- grant  out  NUM_REQ  one-hot current owner; all zero when idle
- busy  out  1  a packet is locked
- abort  out  1  one-cycle pulse when a packet is force-released

Behaviour:
- Reset values: grant=0, busy=0, abort=0, req_ready=0, tx_valid=0, tx_data=0, rr_ptr=(PRIO_REQ+1)%NUM_REQ, state=IDLE.
- Transfer rule: a byte moves when tx_valid && tx_ready in the same cycle.
- FSM has two states, IDLE and LOCKED.
- In IDLE:
  - If any req_valid is high, the winner is PRIO_REQ if its req_valid is high.
  - Otherwise the winner is the first valid index found by searching upward from rr_ptr, wrapping modulo NUM_REQ and skipping PRIO_REQ.
  - On a win: grant is registered, state becomes LOCKED, busy=1 from the next cycle.
  - Arbitration latency is 1 cycle: a req_valid sampled at cycle N gives grant at N+1, and the first transfer is possible at N+1.
- In LOCKED, the datapath is combinational from the owner:
  - tx_data = owner's req_data; tx_valid = owner's req_valid.
  - req_ready[owner] = tx_ready; req_ready is 0 for every non-owner.
  - tx_data is 0 when tx_valid=0.
- Leaving LOCKED: a transfer with the owner's req_last=1 returns the FSM to IDLE on the next cycle.
  - If the owner was not PRIO_REQ, rr_ptr becomes owner+1 (wrapping, skipping PRIO_REQ).
  - This leaves exactly one dead cycle between packets.
- No pre-emption: if PRIO_REQ asserts mid-packet it waits until the current packet ends, then wins the next IDLE arbitration.
- Owner req_valid low while LOCKED: the grant is held and the owner may stall indefinitely unless ARB_TIMEOUT_EN is defined.
- A single-byte packet (req_last on the first byte) is legal: grant lasts exactly the cycles until that transfer.
- Simultaneous requests in IDLE: PRIO_REQ first, then rr order. Requests that lose stay pending with no loss; requesters must hold req_valid.
- Reset mid-packet clears grant immediately (asynchronously). The requester must restart its packet; no partial-packet recovery.
- NUM_REQ=1 degenerates to a pass-through with a 1-cycle grant latency.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on every transfer and on grant, and increments each LOCKED cycle with no transfer.
  - When the count reaches TIMEOUT_CYCLES: abort pulses for 1 cycle, the FSM returns to IDLE, and rr_ptr advances as for a normal packet end.
- Undefined: the counter is absent, abort is tied 0, and a stalled owner holds the channel forever.

Decomposition:
- Package gsm_arb_pkg holds:
  - the arb_state_t enum {IDLE, LOCKED};
  - localparam BYTE_W=8;
  - a function next_rr_idx(ptr, skip, n) that wraps and skips.
- One sub-module, gsm_rr_picker: a combinational priority + round-robin winner selector taking req_valid, rr_ptr and PRIO_REQ, returning a one-hot winner.
- The FSM, lock logic and timeout stay in gsm_tx_arbiter.

Test Plan:
- Single source: req1 sends 3 bytes 0x41,0x54,0x0D (last on 0x0D), tx_ready=1 → grant=3'b010 one cycle after req_valid; tx_data sequence 41,54,0D on consecutive cycles; busy drops the cycle after 0D.
- Priority: req0 and req2 both valid in IDLE → req0 granted first; req2 granted after req0's last byte plus one idle cycle.
- No pre-emption: req2 mid-way through a 4-byte packet, req0 asserts → req2 completes all 4 bytes, then req0 is granted.
- Round-robin: req1 and req2 each send continuous 1-byte packets → grants alternate 010,100,010,100.
- Back-pressure: tx_ready low for 5 cycles mid-packet → tx_data holds, req_ready[owner]=0, no byte lost or duplicated.
- With ARB_TIMEOUT_EN, TIMEOUT_CYCLES=10, owner drops req_valid after byte 1 → abort pulses after exactly 10 stalled cycles, grant clears, a waiting req2 is granted next cycle.
